data_cache: RTL

Direct-mapped, write-back, write-allocate data cache between the CPU load/store path and the byte-addressable data memory. It services word and byte accesses (LW, LBU, SW, SB) from its own storage. On a miss it acts as the initiator towards the data memory: it first writes back the dirty victim line, then refills the new line, using only word (funct3 = 010) transfers with combinational read data.

---
 rtl/data_cache.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache with a word-serial
// writeback/refill FSM. Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module data_cache #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 17,
   parameter int SETS           = 64,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_req_i,
   input  logic                  cpu_we_i,
   input  logic [2:0]            cpu_funct3_i,
   input  logic [DATA_WIDTH-1:0] cpu_addr_i,
   input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
   output logic [DATA_WIDTH-1:0] cpu_rdata_o,
   output logic                  cpu_stall_o,
   output logic [DATA_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_write_data_o,
   output logic                  mem_write_en_o,
   output logic [2:0]            mem_funct3_o,
   input  logic [DATA_WIDTH-1:0] mem_read_data_i,
   output logic [31:0]           hit_count_o,
   output logic [31:0]           miss_count_o
);
   localparam int OB = 2;
   localparam int WB = $clog2(WORDS_PER_LINE);
   localparam int IB = $clog2(SETS);
   localparam int TB = ADDR_WIDTH - IB - WB - OB;
   localparam logic [WB-1:0] LAST_WORD = WB'(WORDS_PER_LINE - 1);

   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

   state_t                state_q;
   logic [WB-1:0]         cnt_q;
   logic [SETS-1:0]       valid_q;
   logic [SETS-1:0]       dirty_q;
   logic [TB-1:0]         tag_q  [SETS];
   logic [DATA_WIDTH-1:0] data_q [SETS*WORDS_PER_LINE];

   logic [TB-1:0]         req_tag;
   logic [IB-1:0]         req_idx;
   logic [WB-1:0]         req_word;
   logic [1:0]            req_byte;
   logic                  is_word, funct_ok, hit, access, access_hit, access_miss;
   logic [DATA_WIDTH-1:0] hit_word, victim_word, store_word;
   logic [ADDR_WIDTH-1:0] xfer_addr;
   logic                  unused_bits;

   assign req_tag     = cpu_addr_i[ADDR_WIDTH-1 -: TB];
   assign req_idx     = cpu_addr_i[OB+WB +: IB];
   assign req_word    = cpu_addr_i[OB +: WB];
   assign req_byte    = cpu_addr_i[1:0];
   assign unused_bits = ^cpu_addr_i[DATA_WIDTH-1:ADDR_WIDTH];

   // Stores accept SB/SW, loads accept LW/LBU; anything else is a silent no-op.
   assign is_word     = (cpu_funct3_i == 3'b010);
   assign funct_ok    = cpu_we_i ? (is_word || cpu_funct3_i == 3'b000)
                                 : (is_word || cpu_funct3_i == 3'b100);
   assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign access      = cpu_req_i && funct_ok && (state_q == IDLE);
   assign access_hit  = access && hit;
   assign access_miss = access && !hit;
   assign hit_word    = data_q[{req_idx, req_word}];
   assign victim_word = data_q[{req_idx, cnt_q}];

   always_comb begin
      store_word = hit_word;
      if (is_word)
         store_word = cpu_wdata_i;
      else
         store_word[{req_byte, 3'b000} +: 8] = cpu_wdata_i[7:0];
   end

   always_comb begin
      cpu_rdata_o = '0;
      if (access_hit && !cpu_we_i)
         cpu_rdata_o = is_word ? hit_word
                               : {{(DATA_WIDTH-8){1'b0}}, hit_word[{req_byte, 3'b000} +: 8]};
   end

   assign cpu_stall_o = (state_q != IDLE) || access_miss;

   always_comb begin
      xfer_addr = '0;
      case (state_q)
         WRITEBACK: xfer_addr = {tag_q[req_idx], req_idx, cnt_q, 2'b00};
         REFILL:    xfer_addr = {req_tag, req_idx, cnt_q, 2'b00};
         default:   xfer_addr = '0;
      endcase
   end

   assign mem_addr_o       = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, xfer_addr};
   assign mem_write_en_o   = (state_q == WRITEBACK);
   assign mem_write_data_o = mem_write_en_o ? victim_word : '0;
   assign mem_funct3_o     = 3'b010;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (access_miss)
                  state_q <= (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : REFILL;
               else if (access_hit && cpu_we_i)
                  dirty_q[req_idx] <= 1'b1;
            end
            WRITEBACK: begin
               if (cnt_q == LAST_WORD) begin
                  cnt_q   <= '0;
                  state_q <= REFILL;
               end else begin
                  cnt_q <= cnt_q + WB'(1);
               end
            end
            REFILL: begin
               if (cnt_q == LAST_WORD) begin
                  cnt_q            <= '0;
                  valid_q[req_idx] <= 1'b1;
                  dirty_q[req_idx] <= 1'b0;
                  state_q          <= IDLE;
               end else begin
                  cnt_q <= cnt_q + WB'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Tag and line storage need no reset: valid bits gate every use.
   always_ff @(posedge clk) begin
      if (state_q == REFILL) begin
         data_q[{req_idx, cnt_q}] <= mem_read_data_i;
         if (cnt_q == LAST_WORD)
            tag_q[req_idx] <= req_tag;
      end else if (access_hit && cpu_we_i) begin
         data_q[{req_idx, req_word}] <= store_word;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;
   logic        refill_done_q;

   // The IDLE cycle right after a refill completes the missed access; it is not a new hit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q     <= '0;
         miss_cnt_q    <= '0;
         refill_done_q <= 1'b0;
      end else begin
         refill_done_q <= (state_q == REFILL) && (cnt_q == LAST_WORD);
         if (access_hit && !refill_done_q && hit_cnt_q != '1)
            hit_cnt_q <= hit_cnt_q + 32'd1;
         if (access_miss && miss_cnt_q != '1)
            miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_count_o  = hit_cnt_q;
   assign miss_count_o = miss_cnt_q;
`else
   assign hit_count_o  = '0;
   assign miss_count_o = '0;
`endif

endmodule
